// File: rtl/scp_run_pkg.sv
// Shared types for the SCP run controller: FSM state encoding and store counter width.
package scp_run_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } scp_run_state_t;

  localparam int STORE_CNT_W = 16;

endpackage

// File: rtl/scp_cycle_counter.sv
// Clear/enable up-counter with a terminal-match flag; clear has priority over enable.
module scp_cycle_counter #(
  parameter int           W     = 32,
  parameter logic [W-1:0] MATCH = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_match
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count    = count_reg;
  assign at_match = (count_reg == MATCH);

endmodule

// File: rtl/scp_run_ctrl.sv
// SCP run controller: core reset sequencing, RUN cycle counting, signature-store verdict and timeout.
// Optional store counter output enabled by defining SCP_RUN_STORE_CNT_EN.
module scp_run_ctrl
  import scp_run_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 32,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int PASS_ADDR      = 84,
  parameter int PASS_DATA      = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   memwrite,
  input  logic [DATA_W-1:0]      dataadr,
  input  logic [DATA_W-1:0]      writedata,
  output logic                   core_reset,
  output logic                   running,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
`ifdef SCP_RUN_STORE_CNT_EN
  output logic [STORE_CNT_W-1:0] store_count,
`endif
  output logic [CNT_W-1:0]       cycle_count
);

  // Hold counter also takes the increment on the edge leaving HOLD, so it must reach RESET_CYCLES.
  localparam int HOLD_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  scp_run_state_t state_reg;

  logic              terminal;
  logic              restart_go;
  logic              hold_done;
  logic              timeout_hit;
  logic              qual_write;
  logic              sig_pass;
  logic [HOLD_W-1:0] unused_hold_count;

  assign terminal   = (state_reg == ST_PASS) || (state_reg == ST_FAIL) ||
                      (state_reg == ST_TIMEOUT);
  assign restart_go = terminal && restart;
  assign qual_write = (state_reg == ST_RUN) && memwrite &&
                      (dataadr == DATA_W'(PASS_ADDR));
  assign sig_pass   = (writedata == DATA_W'(PASS_DATA));

  scp_cycle_counter #(
    .W     (HOLD_W),
    .MATCH (HOLD_W'(RESET_CYCLES - 1))
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr      (restart_go),
    .en       (state_reg == ST_HOLD),
    .count    (unused_hold_count),
    .at_match (hold_done)
  );

  // Counts on the exit edge too, so the verdict value includes the write cycle.
  scp_cycle_counter #(
    .W     (CNT_W),
    .MATCH (CNT_W'(TIMEOUT_CYCLES - 1))
  ) u_run_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr      (restart_go),
    .en       (state_reg == ST_RUN),
    .count    (cycle_count),
    .at_match (timeout_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_HOLD;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (hold_done) begin
            state_reg  <= ST_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end
        end
        ST_RUN: begin
          // A signature store beats a coincident timeout.
          if (qual_write) begin
            state_reg  <= sig_pass ? ST_PASS : ST_FAIL;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= sig_pass;
            fail       <= !sig_pass;
          end else if (timeout_hit) begin
            state_reg  <= ST_TIMEOUT;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end
        end
        default: begin
          if (restart) begin
            state_reg <= ST_HOLD;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SCP_RUN_STORE_CNT_EN
  logic [STORE_CNT_W-1:0] store_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_count_reg <= '0;
    end else if (restart_go) begin
      store_count_reg <= '0;
    end else if ((state_reg == ST_RUN) && memwrite && (store_count_reg != '1)) begin
      store_count_reg <= store_count_reg + STORE_CNT_W'(1);
    end
  end

  assign store_count = store_count_reg;
`endif

endmodule

// File: tb/tb_scp_run_ctrl.sv
// Directed bench for scp_run_ctrl with a scoreboard queue of expected status/cycle values.
module tb_scp_run_ctrl;

  logic        clk;
  logic        rst;
  logic        restart;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        core_reset;
  logic        running;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] cycle_count;
`ifdef SCP_RUN_STORE_CNT_EN
  logic [15:0] store_count;
`endif

  // Status word layout: {core_reset, running, done, pass, fail, timeout}
  localparam logic [5:0] S_HOLD = 6'b100000;
  localparam logic [5:0] S_RUN  = 6'b010000;
  localparam logic [5:0] S_PASS = 6'b101100;
  localparam logic [5:0] S_FAIL = 6'b101010;
  localparam logic [5:0] S_TO   = 6'b101001;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  scp_run_ctrl dut (
    .clk         (clk),
    .reset       (rst),
    .restart     (restart),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
`ifdef SCP_RUN_STORE_CNT_EN
    .store_count (store_count),
`endif
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
      $display("chk %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic exp2(input string tag, input logic [5:0] st, input logic [31:0] cc);
    push({tag, "_status"}, {26'd0, st});
    push({tag, "_cycles"}, cc);
  endtask

  task automatic obs2();
    check({26'd0, core_reset, running, done, pass, fail, timeout});
    check(cycle_count);
  endtask

  task automatic drive_write(input logic [31:0] adr, input logic [31:0] dat);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = dat;
  endtask

  task automatic idle_bus();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  // From a terminal state: restart, then two HOLD edges land in RUN with cycle_count 0.
  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst     = 1'b1;
    restart = 1'b0;
    idle_bus();

    @(negedge clk);
    exp2("reset", S_HOLD, 0);
    obs2();

    rst = 1'b0;
    exp2("hold_edge1", S_HOLD, 0);
    step();
    obs2();
    exp2("run_entry", S_RUN, 0);
    step();
    obs2();
    exp2("run_cnt1", S_RUN, 1);
    step();
    obs2();

    // Three non-signature stores, then the pass store in the cycle after 20 RUN cycles.
    drive_write(32'd80, 32'd1);
    step();
    drive_write(32'd4, 32'd7);
    step();
    drive_write(32'd100, 32'd9);
    step();
    idle_bus();
    repeat (16) step();
    exp2("pre_pass", S_RUN, 20);
    obs2();
    drive_write(32'd84, 32'd7);
    exp2("pass", S_PASS, 21);
    step();
    idle_bus();
    obs2();
`ifdef SCP_RUN_STORE_CNT_EN
    push("store_count", 32'd4);
    check({16'd0, store_count});
`endif
    exp2("pass_frozen", S_PASS, 21);
    repeat (3) step();
    obs2();

    restart = 1'b1;
    exp2("restart_hold", S_HOLD, 0);
    step();
    restart = 1'b0;
    obs2();
    exp2("restart_hold2", S_HOLD, 0);
    step();
    obs2();
    exp2("restart_run", S_RUN, 0);
    step();
    obs2();

    drive_write(32'd80, 32'd7);
    exp2("other_addr", S_RUN, 1);
    step();
    idle_bus();
    obs2();
    restart = 1'b1;
    exp2("restart_in_run", S_RUN, 2);
    step();
    restart = 1'b0;
    obs2();
    drive_write(32'd84, 32'd5);
    exp2("fail", S_FAIL, 3);
    step();
    idle_bus();
    obs2();

    do_restart();
    repeat (99) step();
    exp2("pre_timeout", S_RUN, 99);
    obs2();
    exp2("timeout", S_TO, 100);
    step();
    obs2();

    do_restart();
    repeat (99) step();
    drive_write(32'd84, 32'd7);
    exp2("tie_pass", S_PASS, 100);
    step();
    idle_bus();
    obs2();

    do_restart();
    repeat (5) step();
    exp2("async_reset", S_HOLD, 0);
    #2 rst = 1'b1;
    #1 obs2();
    @(negedge clk);
    rst = 1'b0;
    exp2("rerun_hold", S_HOLD, 0);
    step();
    obs2();
    exp2("rerun_run", S_RUN, 0);
    step();
    obs2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scp_run_ctrl.md
# scp_run_ctrl

Synthesizable run controller for the single-cycle processor (SCP). It sequences the core's reset, counts execution cycles, watches the core's data-memory write port for the pass/fail signature store, and enforces a cycle timeout. It sits beside `top` in the bench and on FPGA builds. It replaces the fixed-delay run window with a parametrised, self-terminating verdict.

## Interface
- `DATA_W`, 32: width of `dataadr` and `writedata`.
- `CNT_W`, 32: width of `cycle_count`.
- `RESET_CYCLES`, 2: rising edges for which `core_reset` is held after `reset` releases; must be ≥1.
- `TIMEOUT_CYCLES`, 100: RUN cycles allowed before timeout; must be ≥1 and < 2^CNT_W.
- `PASS_ADDR`, 84: signature store address.
- `PASS_DATA`, 7: signature store value that means pass.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous; from a terminal state, re-runs the sequence.
- `memwrite`  in  1  core data-memory write enable.
- `dataadr`  in  DATA_W  core data-memory address.
- `writedata`  in  DATA_W  core store data.
- `core_reset`  out  1  reset to the SCP core; registered.
- `running`  out  1  high in RUN.
- `done`  out  1  high in any terminal state.
- `pass` / `fail` / `timeout`  out  1  verdict; one-hot when `done`, all low otherwise.
- `cycle_count`  out  CNT_W  RUN cycles elapsed; frozen in terminal states.

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT.
- **HOLD:** `core_reset`=1. The hold counter increments every edge. When it equals RESET_CYCLES-1, the next state is RUN.
- **RUN:** `core_reset`=0 and `cycle_count` increments every edge. A qualifying write is `memwrite`=1 and `dataadr`==PASS_ADDR.
  - Qualifying write with `writedata`==PASS_DATA: go to PASS.
  - Qualifying write with any other `writedata`: go to FAIL.
  - No qualifying write and `cycle_count`==TIMEOUT_CYCLES-1: go to TIMEOUT.
- **PASS, FAIL, TIMEOUT:** terminal states.
  - `core_reset` returns to 1, so the core is frozen.
  - Outputs hold their values until `reset`, or until `restart` is seen.
  - `restart` moves the block to HOLD and clears the hold counter and `cycle_count` on the next edge.
- `restart` is ignored in HOLD and RUN.
- Writes to any other address are ignored. Writes outside RUN are ignored.
- Simultaneous events:
  - A qualifying write in the timeout cycle wins; the result is PASS or FAIL, never TIMEOUT.
  - Asserting `reset` at any time, including mid-RUN, takes effect immediately (asynchronous).

## Timing
- **During `reset`:** state=HOLD, hold counter=0, `core_reset`=1, `cycle_count`=0, and `running`, `done`, `pass`, `fail`, `timeout` are all 0.
- **Reset release:** `core_reset` stays high for exactly RESET_CYCLES rising edges. It falls on the edge that enters RUN, and `running` rises on that same edge.
- **Verdict latency:** one edge after the qualifying write cycle. `done`, the verdict bit and `core_reset` rise together, and `running` falls on that edge.
- **`cycle_count` at verdict:** equals the number of RUN cycles up to and including the write cycle. At timeout it equals TIMEOUT_CYCLES.
- **Counter width:** the counter never wraps, because TIMEOUT_CYCLES bounds it.

## Configuration
- `SCP_RUN_STORE_CNT_EN` defined:
  - Adds output `store_count` (16 bits), which counts every `memwrite`=1 cycle in RUN.
  - It saturates at 16'hFFFF, is frozen in terminal states, and clears on `reset` or `restart`.
- `SCP_RUN_STORE_CNT_EN` undefined:
  - The port and the counter do not exist.
  - All other behaviour is identical.

## Structure
- Package `scp_run_pkg` holds:
  - the state enum typedef `scp_run_state_t`;
  - the `store_count` width localparam (16).
- Sub-module `scp_cycle_counter`: a clear/enable counter with a terminal-match output. It is instantiated for the hold counter and for `cycle_count`.
- Next-state logic and the registered outputs live in `scp_run_ctrl`.

## Test plan
- **Reset sequence:** reset 1→0 at a negedge with defaults. Required: `core_reset` is high for exactly 2 rising edges, then `running`=1 and `cycle_count` increments from 0.
- **Pass:** after 20 RUN cycles, drive `memwrite`=1, `dataadr`=84, `writedata`=7. Required: next edge `pass`=1 and `done`=1; `cycle_count`=21 and stays frozen; `core_reset`=1.
- **Fail:** `memwrite`=1, `dataadr`=84, `writedata`=5. Required: `fail`=1 next edge; a write to `dataadr`=80 with `writedata`=7 earlier in the run causes no verdict.
- **Timeout and tie:** with no writes, `timeout`=1 after 100 RUN cycles and `cycle_count`=100. A repeat run with the 7→84 write in the 100th cycle gives `pass`=1 and `timeout`=0.
- **Mid-run reset and restart:**
  - `reset` pulse asserted mid-RUN: outputs clear asynchronously, and the HOLD sequence repeats.
  - `restart` in PASS: HOLD next edge, all verdicts 0, `cycle_count`=0.
  - `restart` pulsed in RUN: no effect.
- **`SCP_RUN_STORE_CNT_EN`:** with the macro defined, 3 stores to various addresses before the pass store give `store_count`=4 at `done`.
